// File: rtl/camera_pkg.sv
// camera_pkg -- shared types and constants for the camera capture path.
//   cam_state_t   : capture FSM states (IDLE, VBLANK, FRAME)
//   RGB565_*      : field slice positions, used by downstream RGB444 truncation
//   H/V_ACTIVE_DEF: default expected frame geometry
//   COLOR_BARS    : colours of the optional 8-bar test pattern, left to right
//   sat_inc       : saturating increment for the 11-bit row/column counters
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    FRAME  = 2'd2
  } cam_state_t;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;

  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

  localparam int CNT_W = 11;

  localparam logic [15:0] COLOR_BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // Counters stick at all-ones so an overlong line/frame can never wrap
  // back to a value that happens to look correct.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/camera_sync_edge.sv
// camera_sync_edge -- STAGES-deep synchronizer for asynchronous camera pins,
// followed by one output register that doubles as the edge-detect delay flop.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw asynchronous input (WIDTH bits)
//   level      : synchronized value, one register after the sync chain
//   rise, fall : one-cycle strobes on 0->1 / 1->0 of din[0] (EDGE_EN=1),
//                tied low for the data-only variant (EDGE_EN=0)
// level, rise and fall all come out of the same register stage, so every
// instance with the same STAGES stays cycle-aligned with the others.
module camera_sync_edge #(
  parameter int WIDTH   = 1,
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic             rise,
  output logic             fall
);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] level_reg;

  assign sync  = g_stage[STAGES-1].q_reg;
  assign level = level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_reg <= '0;
    else        level_reg <= sync;
  end

  generate
    if (EDGE_EN) begin : g_edge
      logic rise_reg;
      logic fall_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= sync[0] & ~level_reg[0];
          fall_reg <= ~sync[0] & level_reg[0];
        end
      end
      assign rise = rise_reg;
      assign fall = fall_reg;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/camera_read.sv
// camera_read -- oversamples the camera's 8-bit parallel bus and assembles
// RGB565 pixels {first byte, second byte}.
//   system_clock_in : sole clock (>= 4x camera pclk)
//   reset_n_in      : asynchronous active-low reset
//   cam_*_in        : raw camera pins, treated purely as data
//   err_clear_in    : clears line_error / frame_error (a same-cycle set wins)
//   pixel_data/pixel_valid : pixel stream, valid is a one-cycle strobe
//   frame_done      : one-cycle strobe per completed frame, never together
//                     with pixel_valid
//   frame_count     : completed frames, wraps
//   line_error      : sticky, a line had != H_ACTIVE pixels or an odd byte count
//   frame_error     : sticky, a frame had != V_ACTIVE lines
// Build option: define CAMERA_READ_TEST_PATTERN_EN to replace pixel_data with
// 8 vertical colour bars; timing, strobes and error logic are unchanged.
// Capture event to pixel_valid is SYNC_STAGES+2 clocks (SYNC_STAGES >= 2).
module camera_read
  import camera_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        system_clock_in,
  input  logic        reset_n_in,
  input  logic        cam_pclk_in,
  input  logic        cam_href_in,
  input  logic        cam_vsync_in,
  input  logic [7:0]  cam_data_in,
  input  logic        err_clear_in,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        line_error,
  output logic        frame_error
);

  localparam logic [CNT_W-1:0] H_CNT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_CNT = CNT_W'(V_ACTIVE);

  // Synchronized camera signals (all instances share the same depth).
  logic       capture;
  logic       pclk_level_unused, pclk_fall_unused;
  logic       href_level, href_fall, href_rise_unused;
  logic       vsync_level, vsync_rise, vsync_fall;
  logic [7:0] data_sync;
  logic       data_rise_unused, data_fall_unused;

  camera_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_pclk (
    .clk(system_clock_in), .rst_n(reset_n_in), .din(cam_pclk_in),
    .level(pclk_level_unused), .rise(capture), .fall(pclk_fall_unused)
  );

  camera_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_href (
    .clk(system_clock_in), .rst_n(reset_n_in), .din(cam_href_in),
    .level(href_level), .rise(href_rise_unused), .fall(href_fall)
  );

  camera_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_vsync (
    .clk(system_clock_in), .rst_n(reset_n_in), .din(cam_vsync_in),
    .level(vsync_level), .rise(vsync_rise), .fall(vsync_fall)
  );

  camera_sync_edge #(.WIDTH(8), .STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_data (
    .clk(system_clock_in), .rst_n(reset_n_in), .din(cam_data_in),
    .level(data_sync), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  cam_state_t       state_reg, state_next;
  logic             phase_reg, phase_next;
  logic [7:0]       high_reg, high_next;
  logic [CNT_W-1:0] col_reg, col_next;
  logic [CNT_W-1:0] row_reg, row_next;
  logic [15:0]      pixel_data_reg, pixel_data_next;
  logic             pixel_valid_reg, pixel_valid_next;
  logic             frame_done_reg, frame_done_next;
  logic             done_pending_reg, done_pending_next;
  logic [15:0]      frame_count_reg, frame_count_next;
  logic             line_error_reg, line_error_next;
  logic             frame_error_reg, frame_error_next;
  logic             line_err_set, frame_err_set;
  logic             pixel_now;
  logic [15:0]      pixel_value;

`ifdef CAMERA_READ_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [CNT_W-1:0] bar_raw;
  logic [2:0]       bar_idx;
  assign bar_raw     = col_reg / CNT_W'(BAR_W);
  // Columns past the last bar (overlong lines) stay on the last colour.
  assign bar_idx     = (bar_raw > CNT_W'(7)) ? 3'd7 : bar_raw[2:0];
  assign pixel_value = COLOR_BARS[bar_idx];
`else
  assign pixel_value = {high_reg, data_sync};
`endif

  always_comb begin
    state_next        = state_reg;
    phase_next        = phase_reg;
    high_next         = high_reg;
    col_next          = col_reg;
    row_next          = row_reg;
    pixel_data_next   = pixel_data_reg;
    pixel_valid_next  = 1'b0;
    frame_done_next   = done_pending_reg;
    done_pending_next = 1'b0;
    line_err_set      = 1'b0;
    frame_err_set     = 1'b0;
    pixel_now         = 1'b0;

    case (state_reg)
      IDLE: begin
        // Wait for a vertical blank so a partial frame is never emitted.
        if (vsync_level) state_next = VBLANK;
      end
      VBLANK: begin
        if (vsync_fall) begin
          state_next = FRAME;
          row_next   = '0;
          col_next   = '0;
          phase_next = 1'b0;
        end
      end
      FRAME: begin
        if (capture && href_level) begin
          if (!phase_reg) begin
            high_next = data_sync;
          end else begin
            pixel_data_next  = pixel_value;
            pixel_valid_next = 1'b1;
            pixel_now        = 1'b1;
            col_next         = sat_inc(col_reg);
          end
          phase_next = ~phase_reg;
        end
        // A vsync rise with href still high closes the open line as well.
        // The checks use the post-capture column/phase computed above.
        if (href_fall || (vsync_rise && href_level)) begin
          if (phase_next || (col_next != H_CNT)) line_err_set = 1'b1;
          row_next   = sat_inc(row_reg);
          col_next   = '0;
          phase_next = 1'b0;
        end
        if (vsync_rise) begin
          if (row_next != V_CNT) frame_err_set = 1'b1;
          // Keep frame_done off a pixel_valid cycle by deferring it one clock.
          if (pixel_now) done_pending_next = 1'b1;
          else           frame_done_next   = 1'b1;
          state_next = VBLANK;
        end
      end
      default: state_next = IDLE;
    endcase

    frame_count_next = frame_done_next ? frame_count_reg + 16'd1 : frame_count_reg;
    line_error_next  = line_err_set  | (line_error_reg  & ~err_clear_in);
    frame_error_next = frame_err_set | (frame_error_reg & ~err_clear_in);
  end

  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg        <= IDLE;
      phase_reg        <= 1'b0;
      high_reg         <= '0;
      col_reg          <= '0;
      row_reg          <= '0;
      pixel_data_reg   <= '0;
      pixel_valid_reg  <= 1'b0;
      frame_done_reg   <= 1'b0;
      done_pending_reg <= 1'b0;
      frame_count_reg  <= '0;
      line_error_reg   <= 1'b0;
      frame_error_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      phase_reg        <= phase_next;
      high_reg         <= high_next;
      col_reg          <= col_next;
      row_reg          <= row_next;
      pixel_data_reg   <= pixel_data_next;
      pixel_valid_reg  <= pixel_valid_next;
      frame_done_reg   <= frame_done_next;
      done_pending_reg <= done_pending_next;
      frame_count_reg  <= frame_count_next;
      line_error_reg   <= line_error_next;
      frame_error_reg  <= frame_error_next;
    end
  end

  assign pixel_data  = pixel_data_reg;
  assign pixel_valid = pixel_valid_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;
  assign line_error  = line_error_reg;
  assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_camera_read.sv
// tb_camera_read -- self-checking bench for camera_read using a reduced
// frame geometry (H=16, V=6). Random bytes and random pclk phase lengths
// (each half >= 2 system clocks) drive the camera pins; a line/frame level
// model predicts pixels, strobes and sticky flags.
module tb_camera_read;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int SS = 2;

  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pclk, href, vsync, err_clear;
  logic [7:0]  data;
  logic [15:0] pixel_data, frame_count;
  logic        pixel_valid, frame_done, line_error, frame_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor side (written only by the monitor process).
  logic [15:0] got_pix[$];
  int          done_cnt    = 0;
  int          overlap_cnt = 0;

  // Model side (written only by the stimulus process).
  logic [15:0] exp_pix[$];
  bit          exp_line_err;
  bit          exp_frame_err;
  int          exp_frames;

  always #5 clk = ~clk;

  camera_read #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS)) dut (
    .system_clock_in(clk),
    .reset_n_in(rst_n),
    .cam_pclk_in(pclk),
    .cam_href_in(href),
    .cam_vsync_in(vsync),
    .cam_data_in(data),
    .err_clear_in(err_clear),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .line_error(line_error),
    .frame_error(frame_error)
  );

  always @(negedge clk) begin
    if (pixel_valid) got_pix.push_back(pixel_data);
    if (frame_done) done_cnt++;
    if (pixel_valid && frame_done) overlap_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_pixel(input int col, input logic [7:0] hi, input logic [7:0] lo);
`ifdef CAMERA_READ_TEST_PATTERN_EN
    int bi;
    bi = col / (H / 8);
    if (bi > 7) bi = 7;
    return BARS[bi];
`else
    return {hi, lo};
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    pclk = 1'b0;
    data = b;
    tick(int'($urandom_range(2, 3)));
    pclk = 1'b1;
    tick(int'($urandom_range(2, 3)));
  endtask

  // Sends one href-qualified line and updates the model: pixels are the
  // byte pairs, a trailing odd byte is dropped, and any line that is not
  // exactly 2*H bytes flags line_error.
  task automatic send_line(input int len, input bit fixed_first, input bit keep_open);
    logic [7:0] bytes[$];
    logic [7:0] b;
    href = 1'b1;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (fixed_first && i == 0) b = 8'hF8;
      if (fixed_first && i == 1) b = 8'h1F;
      bytes.push_back(b);
      send_byte(b);
    end
    pclk = 1'b0;
    for (int p = 0; p < len / 2; p++)
      exp_pix.push_back(model_pixel(p, bytes[2*p], bytes[2*p+1]));
    if ((len % 2) != 0 || (len / 2) != H) exp_line_err = 1'b1;
    if (!keep_open) begin
      href = 1'b0;
      tick(4 + int'($urandom_range(0, 4)));
    end
  endtask

  // vsync pulse, n_lines lines (line odd_idx gets odd_len bytes), then the
  // closing vsync rise; open_len > 0 adds a line still open at that rise.
  task automatic send_frame(input int n_lines, input int odd_idx, input int odd_len, input int open_len);
    vsync = 1'b1;
    tick(6);
    vsync = 1'b0;
    tick(6);
    for (int l = 0; l < n_lines; l++)
      send_line((l == odd_idx) ? odd_len : 2 * H, l == 0, 1'b0);
    if (open_len > 0) begin
      send_line(open_len, 1'b0, 1'b1);
      vsync = 1'b1;
      tick(6);
      href = 1'b0;
    end else begin
      vsync = 1'b1;
    end
    tick(10);
    if (n_lines + ((open_len > 0) ? 1 : 0) != V) exp_frame_err = 1'b1;
    exp_frames++;
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    exp_line_err  = 1'b0;
    exp_frame_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (pixel_data !== 16'h0) begin n_bad++; $display("FAIL reset_pixel_data got %h exp 0000", pixel_data); end
    n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pixel_valid got %b exp 0", pixel_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    n_cmp++; if (frame_count !== 16'h0) begin n_bad++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
    n_cmp++; if (line_error !== 1'b0) begin n_bad++; $display("FAIL reset_line_error got %b exp 0", line_error); end
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_frame_error got %b exp 0", frame_error); end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_prereset_partial();
    int base;
    int dbase;
    base  = got_pix.size();
    dbase = done_cnt;
    rst_n = 1'b0;
    href  = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(8'($urandom));
    pclk = 1'b0;
    href = 1'b0;
    tick(6);
    send_line(2 * H, 1'b0, 1'b0);
    tick(10);
    exp_pix.delete();
    exp_line_err = 1'b0;
    n_cmp++; if (got_pix.size() - base !== 0) begin n_bad++; $display("FAIL prereset_pixels got %0d exp 0", got_pix.size() - base); end
    n_cmp++; if (done_cnt - dbase !== 0) begin n_bad++; $display("FAIL prereset_frame_done got %0d exp 0", done_cnt - dbase); end
    n_cmp++; if (line_error !== 1'b0) begin n_bad++; $display("FAIL prereset_line_error got %b exp 0", line_error); end
    $display("test_prereset_partial: %0d pixels before first vsync", got_pix.size() - base);
  endtask

  task automatic test_nominal();
    int base;
    int dbase;
    base  = got_pix.size();
    dbase = done_cnt;
    exp_pix.delete();
    send_frame(V, -1, 0, 0);
    n_cmp++; if (got_pix.size() - base !== exp_pix.size()) begin n_bad++; $display("FAIL nominal_count got %0d exp %0d", got_pix.size() - base, exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && base + i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[base+i] !== exp_pix[i]) begin n_bad++; $display("FAIL nominal_pix[%0d] got %h exp %h", i, got_pix[base+i], exp_pix[i]); end
    end
`ifndef CAMERA_READ_TEST_PATTERN_EN
    n_cmp++; if (got_pix.size() <= base || got_pix[base] !== 16'hF81F) begin n_bad++; $display("FAIL nominal_first_pixel got %h exp f81f", (got_pix.size() > base) ? got_pix[base] : 16'hxxxx); end
`endif
    n_cmp++; if (done_cnt - dbase !== 1) begin n_bad++; $display("FAIL nominal_frame_done got %0d exp 1", done_cnt - dbase); end
    n_cmp++; if (frame_count !== 16'(exp_frames)) begin n_bad++; $display("FAIL nominal_frame_count got %0d exp %0d", frame_count, exp_frames); end
    n_cmp++; if (line_error !== exp_line_err) begin n_bad++; $display("FAIL nominal_line_error got %b exp %b", line_error, exp_line_err); end
    n_cmp++; if (frame_error !== exp_frame_err) begin n_bad++; $display("FAIL nominal_frame_error got %b exp %b", frame_error, exp_frame_err); end
    $display("test_nominal: %0d pixels, frame_count %0d", got_pix.size() - base, frame_count);
  endtask

  task automatic test_short_line();
    int base;
    base = got_pix.size();
    exp_pix.delete();
    send_frame(V, 5, 2 * H - 2, 0);
    n_cmp++; if (got_pix.size() - base !== exp_pix.size()) begin n_bad++; $display("FAIL short_count got %0d exp %0d", got_pix.size() - base, exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && base + i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[base+i] !== exp_pix[i]) begin n_bad++; $display("FAIL short_pix[%0d] got %h exp %h", i, got_pix[base+i], exp_pix[i]); end
    end
    n_cmp++; if (line_error !== exp_line_err) begin n_bad++; $display("FAIL short_line_error got %b exp %b", line_error, exp_line_err); end
    n_cmp++; if (frame_error !== exp_frame_err) begin n_bad++; $display("FAIL short_frame_error got %b exp %b", frame_error, exp_frame_err); end
    clear_errors();
    n_cmp++; if (line_error !== exp_line_err) begin n_bad++; $display("FAIL short_cleared_line_error got %b exp %b", line_error, exp_line_err); end
    $display("test_short_line: %0d pixels, errors cleared", got_pix.size() - base);
  endtask

  task automatic test_odd_bytes();
    int base;
    base = got_pix.size();
    exp_pix.delete();
    send_frame(V, 2, 2 * H + 1, 0);
    n_cmp++; if (got_pix.size() - base !== exp_pix.size()) begin n_bad++; $display("FAIL odd_count got %0d exp %0d", got_pix.size() - base, exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && base + i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[base+i] !== exp_pix[i]) begin n_bad++; $display("FAIL odd_pix[%0d] got %h exp %h", i, got_pix[base+i], exp_pix[i]); end
    end
    n_cmp++; if (line_error !== exp_line_err) begin n_bad++; $display("FAIL odd_line_error got %b exp %b", line_error, exp_line_err); end
    n_cmp++; if (frame_error !== exp_frame_err) begin n_bad++; $display("FAIL odd_frame_error got %b exp %b", frame_error, exp_frame_err); end
    clear_errors();
    $display("test_odd_bytes: %0d pixels", got_pix.size() - base);
  endtask

  task automatic test_truncated();
    int base;
    int dbase;
    int obase;
    base  = got_pix.size();
    dbase = done_cnt;
    obase = overlap_cnt;
    exp_pix.delete();
    send_frame(3, -1, 0, 7);
    n_cmp++; if (got_pix.size() - base !== exp_pix.size()) begin n_bad++; $display("FAIL trunc_count got %0d exp %0d", got_pix.size() - base, exp_pix.size()); end
    for (int i = 0; i < exp_pix.size() && base + i < got_pix.size(); i++) begin
      n_cmp++; if (got_pix[base+i] !== exp_pix[i]) begin n_bad++; $display("FAIL trunc_pix[%0d] got %h exp %h", i, got_pix[base+i], exp_pix[i]); end
    end
    n_cmp++; if (done_cnt - dbase !== 1) begin n_bad++; $display("FAIL trunc_frame_done got %0d exp 1", done_cnt - dbase); end
    n_cmp++; if (overlap_cnt - obase !== 0) begin n_bad++; $display("FAIL trunc_overlap got %0d exp 0", overlap_cnt - obase); end
    n_cmp++; if (frame_count !== 16'(exp_frames)) begin n_bad++; $display("FAIL trunc_frame_count got %0d exp %0d", frame_count, exp_frames); end
    n_cmp++; if (frame_error !== exp_frame_err) begin n_bad++; $display("FAIL trunc_frame_error got %b exp %b", frame_error, exp_frame_err); end
    n_cmp++; if (line_error !== exp_line_err) begin n_bad++; $display("FAIL trunc_line_error got %b exp %b", line_error, exp_line_err); end
    clear_errors();
    n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL trunc_cleared_frame_error got %b exp 0", frame_error); end
    $display("test_truncated: %0d pixels, frame_count %0d", got_pix.size() - base, frame_count);
  endtask

`ifdef CAMERA_READ_TEST_PATTERN_EN
  task automatic test_pattern();
    int base;
    base = got_pix.size();
    exp_pix.delete();
    send_frame(V, -1, 0, 0);
    n_cmp++; if (got_pix.size() - base !== V * H) begin n_bad++; $display("FAIL pattern_count got %0d exp %0d", got_pix.size() - base, V * H); end
    if (got_pix.size() - base >= H) begin
      n_cmp++; if (got_pix[base] !== 16'hFFFF) begin n_bad++; $display("FAIL pattern_pix0 got %h exp ffff", got_pix[base]); end
      n_cmp++; if (got_pix[base+H/8] !== 16'hFFE0) begin n_bad++; $display("FAIL pattern_bar1 got %h exp ffe0", got_pix[base+H/8]); end
      n_cmp++; if (got_pix[base+H-1] !== 16'h0000) begin n_bad++; $display("FAIL pattern_last got %h exp 0000", got_pix[base+H-1]); end
    end
    $display("test_pattern: %0d pixels", got_pix.size() - base);
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    pclk          = 1'b0;
    href          = 1'b0;
    vsync         = 1'b0;
    data          = 8'h00;
    err_clear     = 1'b0;
    exp_line_err  = 1'b0;
    exp_frame_err = 1'b0;
    exp_frames    = 0;
    test_reset();
    test_prereset_partial();
    test_nominal();
    test_short_line();
    test_odd_bytes();
    test_truncated();
`ifdef CAMERA_READ_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
